evt_frame_dispatcher: RTL and testbench
=======================================

// Module: evt_frame_dispatcher
// PURPOSE
//  Next-generation peripheral-output event dispatcher. Extracts a 32-bit event from each
//  incoming packet (key, or payload by mode), buffers events in a FIFO (no overwrite) and
//  streams them as AXI-Stream frames to the DMA engine. A frame closes on a size limit or
//  on a periodic microsecond-based tick. Sits between the packet receiver and the DMA engine.
// PARAMETERS
//  PKT_W        72  packet width; key at [39:8], payload at [71:40], payload-present flag at bit 1
//  EVT_CNT_BITS 10  width of frame-size count
//  TCK_CNT_BITS 32  width of tick count (microseconds)
//  FIFO_AW       4  FIFO address bits; depth = 2**FIFO_AW (16)
//  CLK_PER_US   75  clk cycles per microsecond
// PORTS
//  clk              in   1             clock
//  reset            in   1             asynchronous, active-high reset
//  pkt_data_in      in   PKT_W         incoming packet
//  pkt_vld_in       in   1             packet valid
//  pkt_rdy_out      out  1             packet ready (never back-pressures)
//  evt_mode_in      in   1             0: event = key; 1: event = payload if present, else key
//  output_tick_in   in   TCK_CNT_BITS  frame tick period in us; 0 disables tick closing
//  output_size_in   in   EVT_CNT_BITS  max events per frame; 0 treated as 1
//  evt_data_out     out  32            event word
//  evt_keep_out     out  4             byte enables, always 4'b1111
//  evt_last_out     out  1             last word of frame
//  evt_vld_out      out  1             event valid
//  evt_rdy_in       in   1             event ready from DMA engine
//  out_drp_cnt_out  out  1             one-cycle pulse per dropped packet
//  fifo_lvl_out     out  FIFO_AW+1     current FIFO occupancy
// BEHAVIOUR
//  - Reset: pkt_rdy_out=0, evt_vld_out=0, evt_last_out=0, evt_data_out=0, evt_keep_out=4'hF,
//    out_drp_cnt_out=0, fifo_lvl_out=0. All state cleared; partial frame discarded.
//    pkt_rdy_out=1 from the first clk after reset release.
//  - Accept: pkt_vld_in & pkt_rdy_out. Event written to FIFO at that edge.
//    FIFO full (sampled occupancy == depth): packet dropped even if a pop occurs the same cycle;
//    out_drp_cnt_out=1 next cycle.
//  - Output register load: FIFO non-empty & (!evt_vld_out | evt_rdy_in). evt_vld_out holds with
//    stable data/last until evt_rdy_in. Latency into empty, idle block: accept at edge t ->
//    evt_vld_out at edge t+1. Back-to-back accepts with evt_rdy_in=1 sustain 1 word/cycle.
//  - Tick: us_cnt counts CLK_PER_US-1..0. tck_cnt loads output_tick_in and decrements when
//    us_cnt==0. tick = (tck_cnt==0) & (output_tick_in!=0), then tck_cnt reloads. Period does
//    not stall.
//  - frm_cnt: words left in frame; loads max(output_size_in,1) at reset and at each frame start.
//  - FSM OPEN/CLOSING:
//    tick in OPEN with (words sent in frame > 0 | FIFO non-empty) -> CLOSING,
//    close_rem = max(occupancy,1); occupancy excludes a same-cycle push.
//    tick in CLOSING: ignored. tick in OPEN with empty frame and empty FIFO: no action.
//  - Per load: last = (frm_cnt==1) | (CLOSING & close_rem==1).
//    last load -> frm_cnt reload, state OPEN.
//    otherwise -> frm_cnt-1, and close_rem-1 if CLOSING.
//    Tick with empty FIFO and open frame: the next loaded word carries last.
//  - Counter arithmetic is unsigned and never wraps below 0. Config inputs are sampled only at
//    reload points.
// TESTING
//  1 size=4, tick=0, 10 packets back-to-back, rdy=1
//    -> 10 words out in order; last on words 4 and 8; word 10 not last.
//  2 mode=1, packet with payload flag=1, key=0xA, payload=0xB -> 0xB out;
//    payload flag=0 -> key 0xA out.
//  3 rdy=0, 20 packets -> fifo_lvl_out=16, 4 drop pulses;
//    rdy=1 -> 16 words drain, none lost or duplicated.
//  4 size=100, tick=2 (150 clk), 3 packets then idle -> last on word 3 once the tick fires;
//    1 packet after the tick -> carries last=0.
//  5 size=100, tick=1, 1 word sent and accepted, FIFO empty at tick -> next word pushed carries last=1.
//  6 reset asserted mid-frame with evt_vld_out=1 -> all outputs at reset values immediately;
//    first frame after release starts fresh with frm_cnt=size.

Source files
------------

// File: rtl/evt_frame_dispatcher.sv
// Packet-to-AXI-Stream event dispatcher; accept at edge t -> evt_vld_out at t+1, 1 word/cycle sustained.
// Input never stalls (drops with a pulse when 16 events are held); output holds until evt_rdy_in.
module evt_frame_dispatcher #(
  parameter int PKT_W        = 72,
  parameter int EVT_CNT_BITS = 10,
  parameter int TCK_CNT_BITS = 32,
  parameter int FIFO_AW      = 4,
  parameter int CLK_PER_US   = 75
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PKT_W-1:0]        pkt_data_in,
  input  logic                    pkt_vld_in,
  output logic                    pkt_rdy_out,
  input  logic                    evt_mode_in,
  input  logic [TCK_CNT_BITS-1:0] output_tick_in,
  input  logic [EVT_CNT_BITS-1:0] output_size_in,
  output logic [31:0]             evt_data_out,
  output logic [3:0]              evt_keep_out,
  output logic                    evt_last_out,
  output logic                    evt_vld_out,
  input  logic                    evt_rdy_in,
  output logic                    out_drp_cnt_out,
  output logic [FIFO_AW:0]        fifo_lvl_out
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int US_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [0:0] S_OPEN    = 1'b0;
  localparam logic [0:0] S_CLOSING = 1'b1;

  logic                    r_pkt_rdy;
  logic [31:0]             r_mem [DEPTH];
  logic [FIFO_AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_fifo_cnt;
  logic [31:0]             r_evt_dat;
  logic                    r_evt_last, r_evt_vld, r_drp;
  logic [US_W-1:0]         r_us_cnt;
  logic [TCK_CNT_BITS-1:0] r_tck_cnt;
  logic [EVT_CNT_BITS-1:0] r_frm_cnt;
  logic [0:0]              r_state;
  logic [CW-1:0]           r_close_rem;

  logic [31:0]             w_evt;
  logic [CW-1:0]           w_occ, w_fifo_after, w_rem_new;
  logic                    w_acc, w_full, w_push, w_drop, w_fifo_ne, w_load;
  logic [EVT_CNT_BITS-1:0] w_size_eff, w_frm_eff;
  logic                    w_closing, w_last, w_tick, w_frm_busy, w_enter;
  logic                    w_unused;

  assign w_unused = ^{pkt_data_in[7:2], pkt_data_in[0]};

  assign w_evt = (evt_mode_in & pkt_data_in[1]) ? pkt_data_in[71:40] : pkt_data_in[39:8];

  // Occupancy counts the word parked in the output register as well as the FIFO.
  assign w_occ     = r_fifo_cnt + CW'(r_evt_vld);
  assign w_acc     = pkt_vld_in & r_pkt_rdy;
  assign w_full    = (w_occ == CW'(DEPTH));
  assign w_push    = w_acc & ~w_full;
  assign w_drop    = w_acc & w_full;
  assign w_fifo_ne = (r_fifo_cnt != '0);
  assign w_load    = w_fifo_ne & (~r_evt_vld | evt_rdy_in);

  // r_frm_cnt == 0 marks a fresh frame; the size limit is sampled on its first word.
  assign w_size_eff = (output_size_in == '0) ? EVT_CNT_BITS'(1) : output_size_in;
  assign w_frm_eff  = (r_frm_cnt == '0) ? w_size_eff : r_frm_cnt;
  assign w_closing  = (r_state == S_CLOSING);
  assign w_last     = (w_frm_eff == EVT_CNT_BITS'(1)) | (w_closing & (r_close_rem == CW'(1)));

  assign w_tick       = (r_tck_cnt == '0) & (output_tick_in != '0);
  assign w_frm_busy   = (r_frm_cnt != '0) | w_fifo_ne;
  assign w_fifo_after = r_fifo_cnt - CW'(w_load);
  assign w_rem_new    = (w_fifo_after == '0) ? CW'(1) : w_fifo_after;
  // A same-cycle size-limited last that empties everything leaves nothing to close.
  assign w_enter      = w_tick & ~w_closing & w_frm_busy &
                        ~(w_load & w_last & (w_fifo_after == '0));

  assign pkt_rdy_out     = r_pkt_rdy;
  assign evt_data_out    = r_evt_dat;
  assign evt_keep_out    = 4'hF;
  assign evt_last_out    = r_evt_last;
  assign evt_vld_out     = r_evt_vld;
  assign out_drp_cnt_out = r_drp;
  assign fifo_lvl_out    = w_occ;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_rdy  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_drp      <= 1'b0;
    end else begin
      r_pkt_rdy <= 1'b1;
      r_drp     <= w_drop;
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_load})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evt_dat  <= '0;
      r_evt_last <= 1'b0;
      r_evt_vld  <= 1'b0;
    end else if (w_load) begin
      r_evt_dat  <= r_mem[r_rd_ptr];
      r_evt_last <= w_last;
      r_evt_vld  <= 1'b1;
    end else if (evt_rdy_in) begin
      r_evt_last <= 1'b0;
      r_evt_vld  <= 1'b0;
    end
  end

  // Free-running microsecond prescaler; the tick period never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_us_cnt  <= US_W'(CLK_PER_US - 1);
      r_tck_cnt <= '0;
    end else begin
      if (r_us_cnt == '0) r_us_cnt <= US_W'(CLK_PER_US - 1);
      else                r_us_cnt <= r_us_cnt - US_W'(1);
      if (r_tck_cnt == '0)     r_tck_cnt <= output_tick_in;
      else if (r_us_cnt == '0) r_tck_cnt <= r_tck_cnt - TCK_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frm_cnt   <= '0;
      r_state     <= S_OPEN;
      r_close_rem <= '0;
    end else begin
      if (w_load) r_frm_cnt <= w_last ? '0 : (w_frm_eff - EVT_CNT_BITS'(1));
      if (w_enter) begin
        r_state     <= S_CLOSING;
        r_close_rem <= w_rem_new;
      end else if (w_load & w_closing) begin
        if (w_last) r_state     <= S_OPEN;
        else        r_close_rem <= r_close_rem - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_evt_frame_dispatcher.sv
// Self-checking bench for evt_frame_dispatcher: vector table plus scoreboard of expected output words.
module tb_evt_frame_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] pkt_data_in;
  logic        pkt_vld_in;
  logic        pkt_rdy_out;
  logic        evt_mode_in;
  logic [31:0] output_tick_in;
  logic [9:0]  output_size_in;
  logic [31:0] evt_data_out;
  logic [3:0]  evt_keep_out;
  logic        evt_last_out;
  logic        evt_vld_out;
  logic        evt_rdy_in;
  logic        out_drp_cnt_out;
  logic [4:0]  fifo_lvl_out;

  always #5 clk = ~clk;

  evt_frame_dispatcher dut (
    .clk             (clk),
    .reset           (reset),
    .pkt_data_in     (pkt_data_in),
    .pkt_vld_in      (pkt_vld_in),
    .pkt_rdy_out     (pkt_rdy_out),
    .evt_mode_in     (evt_mode_in),
    .output_tick_in  (output_tick_in),
    .output_size_in  (output_size_in),
    .evt_data_out    (evt_data_out),
    .evt_keep_out    (evt_keep_out),
    .evt_last_out    (evt_last_out),
    .evt_vld_out     (evt_vld_out),
    .evt_rdy_in      (evt_rdy_in),
    .out_drp_cnt_out (out_drp_cnt_out),
    .fifo_lvl_out    (fifo_lvl_out)
  );

  typedef struct {
    logic        mode;
    logic        flag;
    logic [31:0] key;
    logic [31:0] pay;
    logic [31:0] exp_dat;
    logic        exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;
  int   drops    = 0;
  int   d0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: sample outputs on the falling edge, return just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (evt_vld_out && evt_rdy_in) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h required=none", evt_data_out);
      end else begin
        e = sb.pop_front();
        chk("word_data", {32'd0, evt_data_out}, {32'd0, e.dat});
        chk("word_last", {63'd0, evt_last_out}, {63'd0, e.last});
        chk("word_keep", {60'd0, evt_keep_out}, 64'hF);
      end
    end
    if (out_drp_cnt_out) drops++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic mode, input logic flag, input logic [31:0] key,
                      input logic [31:0] pay, input logic exp_en,
                      input logic [31:0] edat, input logic elast);
    pkt_data_in = {pay, key, 6'd0, flag, 1'b0};
    evt_mode_in = mode;
    pkt_vld_in  = 1'b1;
    if (exp_en) sb.push_back('{edat, elast});
    step();
    pkt_vld_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) step();
    chk("drain_left", 64'(sb.size()), 64'd0);
    chk("idle_after_drain", {63'd0, evt_vld_out}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    pkt_data_in    = '0;
    pkt_vld_in     = 1'b0;
    evt_mode_in    = 1'b0;
    output_tick_in = 32'd0;
    output_size_in = 10'd1;
    evt_rdy_in     = 1'b1;

    for (int i = 0; i < 10; i++)
      vecs[i] = '{1'b0, i[0], 32'h1000 + i, 32'hBEEF0000 + i, 32'h1000 + i, (i == 3 || i == 7)};
    vecs[10] = '{1'b1, 1'b1, 32'hA, 32'hB, 32'hB, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'hA, 32'hB, 32'hA, 1'b1};

    // Reset values
    #2;
    chk("rst_pkt_rdy", {63'd0, pkt_rdy_out}, 64'd0);
    chk("rst_vld", {63'd0, evt_vld_out}, 64'd0);
    chk("rst_last", {63'd0, evt_last_out}, 64'd0);
    chk("rst_data", {32'd0, evt_data_out}, 64'd0);
    chk("rst_keep", {60'd0, evt_keep_out}, 64'hF);
    chk("rst_drp", {63'd0, out_drp_cnt_out}, 64'd0);
    chk("rst_lvl", {59'd0, fifo_lvl_out}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rdy_before_clk", {63'd0, pkt_rdy_out}, 64'd0);
    step();
    chk("rdy_after_clk", {63'd0, pkt_rdy_out}, 64'd1);

    // Latency and hold under back-pressure (size 1: every word is last)
    evt_rdy_in = 1'b0;
    send(1'b0, 1'b0, 32'h55, 32'h66, 1'b1, 32'h55, 1'b1);
    chk("lat_not_early", {63'd0, evt_vld_out}, 64'd0);
    chk("lat_lvl_fifo", {59'd0, fifo_lvl_out}, 64'd1);
    step();
    chk("lat_vld", {63'd0, evt_vld_out}, 64'd1);
    chk("lat_data", {32'd0, evt_data_out}, 64'h55);
    chk("lat_lvl_reg", {59'd0, fifo_lvl_out}, 64'd1);
    step();
    step();
    chk("hold_vld", {63'd0, evt_vld_out}, 64'd1);
    chk("hold_data", {32'd0, evt_data_out}, 64'h55);
    chk("hold_last", {63'd0, evt_last_out}, 64'd1);
    evt_rdy_in = 1'b1;
    drain(20);

    // Size-4 framing and mode selection, back-to-back
    output_size_in = 10'd4;
    for (int i = 0; i < 12; i++)
      send(vecs[i].mode, vecs[i].flag, vecs[i].key, vecs[i].pay, 1'b1, vecs[i].exp_dat, vecs[i].exp_last);
    chk("throughput_backlog", 64'(sb.size()), 64'd2);
    drain(20);

    // Overflow: 16 held, 4 dropped, then full drain
    evt_rdy_in = 1'b0;
    d0 = drops;
    for (int i = 0; i < 20; i++)
      send(1'b0, 1'b0, 32'h2000 + i, 32'h0, (i < 16), 32'h2000 + i, (i % 4) == 3);
    step();
    step();
    chk("full_lvl", {59'd0, fifo_lvl_out}, 64'd16);
    chk("drop_pulses", 64'(drops - d0), 64'd4);
    evt_rdy_in = 1'b1;
    drain(60);

    // Tick closes a held partial frame; next word starts a new frame
    output_size_in = 10'd100;
    output_tick_in = 32'd2;
    evt_rdy_in     = 1'b0;
    send(1'b0, 1'b0, 32'h3000, 32'h0, 1'b1, 32'h3000, 1'b0);
    send(1'b0, 1'b0, 32'h3001, 32'h0, 1'b1, 32'h3001, 1'b0);
    send(1'b0, 1'b0, 32'h3002, 32'h0, 1'b1, 32'h3002, 1'b1);
    repeat (160) step();
    chk("tick_hold_lvl", {59'd0, fifo_lvl_out}, 64'd3);
    evt_rdy_in = 1'b1;
    drain(20);
    send(1'b0, 1'b0, 32'h3003, 32'h0, 1'b1, 32'h3003, 1'b0);
    drain(20);

    // Tick with empty FIFO and open frame: next word is last
    output_tick_in = 32'd1;
    repeat (140) step();
    send(1'b0, 1'b0, 32'h3004, 32'h0, 1'b1, 32'h3004, 1'b1);
    drain(20);
    // Ticks over an empty frame do nothing
    repeat (100) step();
    send(1'b0, 1'b0, 32'h3005, 32'h0, 1'b1, 32'h3005, 1'b0);
    drain(20);

    // Reset mid-frame with a word on the output
    output_tick_in = 32'd0;
    output_size_in = 10'd3;
    evt_rdy_in     = 1'b0;
    send(1'b0, 1'b0, 32'h4000, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk("pre_rst_vld", {63'd0, evt_vld_out}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", {63'd0, evt_vld_out}, 64'd0);
    chk("mid_rst_last", {63'd0, evt_last_out}, 64'd0);
    chk("mid_rst_data", {32'd0, evt_data_out}, 64'd0);
    chk("mid_rst_lvl", {59'd0, fifo_lvl_out}, 64'd0);
    chk("mid_rst_pkt_rdy", {63'd0, pkt_rdy_out}, 64'd0);
    sb.delete();
    step();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_rdy", {63'd0, pkt_rdy_out}, 64'd1);
    evt_rdy_in = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1'b0, 1'b0, 32'h5000 + i, 32'h0, 1'b1, 32'h5000 + i, (i == 2));
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
